// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the four-requester RAM arbiter: requester ids and the
// address range helper.
package mem_arbiter_pkg;

  localparam int unsigned NUM_REQ        = 4;
  localparam int unsigned ADDR_W_DEFAULT = 12;

  // Index order is also the priority order (lowest index wins).
  localparam int unsigned ARB_LD = 0;
  localparam int unsigned ARB_DW = 1;
  localparam int unsigned ARB_DR = 2;
  localparam int unsigned ARB_IR = 3;

  typedef enum logic [1:0] {
    ReqLd = 2'd0,
    ReqDw = 2'd1,
    ReqDr = 2'd2,
    ReqIr = 2'd3
  } req_e;

  // True when any byte-address bit above the RAM word range is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return hi != '0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core/loader request ports and RAM port of the arbiter, bundled. The slave
// modport is the arbiter's view; master is the requester/RAM environment.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = 32
);

  logic              ir_en;
  logic [31:0]       ir_addr;
  logic [DATA_W-1:0] ir_data;
  logic              ir_valid;
  logic              dr_en;
  logic [31:0]       dr_addr;
  logic [DATA_W-1:0] dr_data;
  logic              dr_valid;
  logic              dw_en;
  logic [31:0]       dw_addr;
  logic [DATA_W-1:0] dw_data;
  logic              ld_en;
  logic [31:0]       ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              err_range;
  logic              err_overrun;

  modport master (
    output ir_en, ir_addr, dr_en, dr_addr, dw_en, dw_addr, dw_data,
    output ld_en, ld_addr, ld_data, ram_rdata,
    input  ir_data, ir_valid, dr_data, dr_valid,
    input  ram_en, ram_we, ram_addr, ram_wdata, err_range, err_overrun
  );

  modport slave (
    input  ir_en, ir_addr, dr_en, dr_addr, dw_en, dw_addr, dw_data,
    input  ld_en, ld_addr, ld_data, ram_rdata,
    output ir_data, ir_valid, dr_data, dr_valid,
    output ram_en, ram_we, ram_addr, ram_wdata, err_range, err_overrun
  );

endinterface

// File: rtl/mem_arb_slot.sv
// One requester slot: one-deep pending request, overrun detect and, for read
// requesters, the returned-data hold register with its valid flag.
module mem_arb_slot #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          IS_READ = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              win_i,
  input  logic              ret_i,
  input  logic [DATA_W-1:0] ret_data_i,
  output logic              cand_o,
  output logic [31:0]       addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overrun_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic              pend_q, pend_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A pending request is served before a same-cycle strobe, which then
  // becomes the new pending request.
  always_comb begin
    pend_d = pend_q & ~win_i;
    addr_d = addr_q;
    data_d = data_q;
    if (strobe_i) begin
      pend_d = ~(win_i & ~pend_q);
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign cand_o    = strobe_i | pend_q;
  assign addr_o    = pend_q ? addr_q : addr_i;
  assign data_o    = pend_q ? data_q : data_i;
  assign overrun_o = strobe_i & pend_q & ~win_i;

  if (IS_READ) begin : g_rd
    logic              hold_q, hold_unused;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              valid_d;
    logic              ret_live;

    // A return that overlaps a newer outstanding request is stale.
    always_comb begin
      ret_live = ret_i & ~pend_q;
      rdata_d  = ret_live ? ret_data_i : rdata_q;
      valid_d  = strobe_i ? 1'b0 : (ret_live | hold_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
        hold_q  <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        hold_q  <= valid_d;
      end
    end

    assign hold_unused = 1'b0;
    assign rd_data_o   = ret_live ? ret_data_i : rdata_q;
    assign rd_valid_o  = ret_live | hold_q;
  end else begin : g_wr
    logic unused_ret;
    assign unused_ret = ^{ret_i, ret_data_i};
    assign rd_data_o  = '0;
    assign rd_valid_o = 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port synchronous RAM among loader
// write, data write, data read and instruction read requesters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] strobe, cand, win, ret, ovr;
  logic [31:0]        in_addr  [NUM_REQ];
  logic [DATA_W-1:0]  in_data  [NUM_REQ];
  logic [31:0]        addr_s   [NUM_REQ];
  logic [DATA_W-1:0]  data_s   [NUM_REQ];
  logic [DATA_W-1:0]  rd_data_s[NUM_REQ];
  logic [NUM_REQ-1:0] rd_valid_s;

  logic              any, sel_oor, sel_wr, ram_en;
  req_e              win_id;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_data, ret_data;

  logic ret_vld_q, ret_vld_d;
  req_e ret_id_q, ret_id_d;
  logic ret_oor_q, ret_oor_d;
  logic err_range_q, err_range_d;
  logic err_ovr_q, err_ovr_d;

  always_comb begin
    strobe          = '0;
    strobe[ARB_LD]  = bus.ld_en;
    strobe[ARB_DW]  = bus.dw_en;
    strobe[ARB_DR]  = bus.dr_en;
    strobe[ARB_IR]  = bus.ir_en;
    in_addr[ARB_LD] = bus.ld_addr;
    in_addr[ARB_DW] = bus.dw_addr;
    in_addr[ARB_DR] = bus.dr_addr;
    in_addr[ARB_IR] = bus.ir_addr;
    in_data[ARB_LD] = bus.ld_data;
    in_data[ARB_DW] = bus.dw_data;
    in_data[ARB_DR] = '0;
    in_data[ARB_IR] = '0;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    mem_arb_slot #(
      .DATA_W (DATA_W),
      .IS_READ(i == ARB_DR || i == ARB_IR)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .strobe_i  (strobe[i]),
      .addr_i    (in_addr[i]),
      .data_i    (in_data[i]),
      .win_i     (win[i]),
      .ret_i     (ret[i]),
      .ret_data_i(ret_data),
      .cand_o    (cand[i]),
      .addr_o    (addr_s[i]),
      .data_o    (data_s[i]),
      .overrun_o (ovr[i]),
      .rd_data_o (rd_data_s[i]),
      .rd_valid_o(rd_valid_s[i])
    );
  end

  always_comb begin
    any    = |cand;
    win_id = ReqIr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) win_id = req_e'(i[1:0]);
    end
    win      = any ? (4'b0001 << win_id) : '0;
    sel_addr = addr_s[win_id];
    sel_data = data_s[win_id];
    sel_oor  = addr_oor(sel_addr, ADDR_W);
    sel_wr   = (win_id == ReqLd) || (win_id == ReqDw);
    // Out-of-range accesses still own the cycle but never reach the RAM.
    ram_en   = any & ~sel_oor & rst_n;

    ret_vld_d   = any & ~sel_wr;
    ret_id_d    = win_id;
    ret_oor_d   = sel_oor;
    err_range_d = err_range_q | (any & sel_oor);
    err_ovr_d   = err_ovr_q | (|ovr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_vld_q   <= 1'b0;
      ret_id_q    <= ReqLd;
      ret_oor_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      ret_vld_q   <= ret_vld_d;
      ret_id_q    <= ret_id_d;
      ret_oor_q   <= ret_oor_d;
      err_range_q <= err_range_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign ret      = ret_vld_q ? (4'b0001 << ret_id_q) : '0;
  assign ret_data = ret_oor_q ? '0 : bus.ram_rdata;

  assign bus.ram_en      = ram_en;
  assign bus.ram_we      = ram_en & sel_wr;
  assign bus.ram_addr    = (any && rst_n) ? sel_addr[ADDR_W+1:2] : '0;
  assign bus.ram_wdata   = (ram_en && sel_wr) ? sel_data : '0;
  assign bus.ir_data     = rd_data_s[ARB_IR];
  assign bus.ir_valid    = rd_valid_s[ARB_IR];
  assign bus.dr_data     = rd_data_s[ARB_DR];
  assign bus.dr_valid    = rd_valid_s[ARB_DR];
  assign bus.err_range   = err_range_q;
  assign bus.err_overrun = err_ovr_q;

  logic unused_sink;
  assign unused_sink = ^{rd_data_s[ARB_LD], rd_data_s[ARB_DW], rd_valid_s[ARB_LD],
                         rd_valid_s[ARB_DW], sel_addr[1:0]};

  // The loader only runs while the core is held in reset.
  ld_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ld_en |-> !(bus.ir_en || bus.dr_en || bus.dw_en));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and a read-return
// scoreboard holding expected data and return cycle per read port.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    string         tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t ir_q[$];
  exp_t dr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic idle();
    bus.ir_en = 1'b0;
    bus.dr_en = 1'b0;
    bus.dw_en = 1'b0;
    bus.ld_en = 1'b0;
  endtask

  task automatic push(input bit is_dr, input string tag, input logic [DW-1:0] d, input int due);
    exp_t e;
    e.tag  = tag;
    e.data = d;
    e.due  = due;
    if (is_dr) dr_q.push_back(e);
    else       ir_q.push_back(e);
  endtask

  // Entered at a sampling point; waits a bounded number of cycles for valid.
  task automatic wait_rd(input bit is_dr);
    exp_t e;
    int   n;
    if (is_dr) e = dr_q.pop_front();
    else       e = ir_q.pop_front();
    n = 0;
    while (!(is_dr ? bus.dr_valid : bus.ir_valid) && n < 8) begin
      cyc();
      #1;
      n++;
    end
    chk({e.tag, "_valid"}, is_dr ? bus.dr_valid : bus.ir_valid, 1);
    chk({e.tag, "_cycle"}, cnt, e.due);
    chk({e.tag, "_data"}, is_dr ? bus.dr_data : bus.ir_data, e.data);
  endtask

  logic [31:0] pre_addr [6];
  logic [31:0] pre_data [6];

  initial begin
    pre_addr = '{32'h10, 32'h20, 32'h00, 32'h30, 32'h34, 32'h40};
    pre_data = '{32'h00500093, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0};
    idle();
    bus.ir_addr = '0; bus.dr_addr = '0; bus.dw_addr = '0; bus.ld_addr = '0;
    bus.dw_data = '0; bus.ld_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_ir", {bus.ir_valid, bus.ir_data}, 0);
    chk("rst_dr", {bus.dr_valid, bus.dr_data}, 0);
    chk("rst_err", {bus.err_range, bus.err_overrun}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc();
      idle();
      bus.ld_en = 1'b1; bus.ld_addr = pre_addr[i]; bus.ld_data = pre_data[i];
      #1;
      chk("ld_write", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr), bus.ram_wdata},
          {1'b1, 1'b1, 20'(pre_addr[i] >> 2), pre_data[i]});
    end

    // Uncontended instruction read.
    cyc(); idle();
    bus.ir_en = 1'b1; bus.ir_addr = 32'h10;
    #1;
    chk("ir_ram", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}, {1'b1, 1'b0, 20'd4});
    push(0, "ir_plain", 32'h00500093, cnt + 1);
    cyc(); idle(); #1;
    wait_rd(0);
    cyc(); cyc(); #1;
    chk("ir_hold", {bus.ir_valid, bus.ir_data}, {1'b1, 32'h00500093});

    // Byte offset bits are ignored.
    cyc(); bus.ir_en = 1'b1; bus.ir_addr = 32'h13;
    push(0, "ir_off", 32'h00500093, cnt + 1);
    cyc(); idle(); #1;
    wait_rd(0);

    // dr and ir collide: dr first.
    cyc();
    bus.dr_en = 1'b1; bus.dr_addr = 32'h20; bus.ir_en = 1'b1; bus.ir_addr = 32'h0;
    #1;
    chk("col_c0_addr", bus.ram_addr, 8);
    push(1, "col_dr", 32'h11111111, cnt + 1);
    push(0, "col_ir", 32'h22222222, cnt + 2);
    cyc(); idle(); #1;
    chk("col_c1", {bus.ram_en, 20'(bus.ram_addr)}, {1'b1, 20'd0});
    wait_rd(1);
    wait_rd(0);

    // Same-word dw and dr: write lands first.
    cyc();
    bus.dw_en = 1'b1; bus.dw_addr = 32'h40; bus.dw_data = 32'hDEADBEEF;
    bus.dr_en = 1'b1; bus.dr_addr = 32'h40;
    #1;
    chk("wr_c0", {bus.ram_we, 20'(bus.ram_addr), bus.ram_wdata}, {1'b1, 20'd16, 32'hDEADBEEF});
    push(1, "wr_dr", 32'hDEADBEEF, cnt + 2);
    cyc(); idle(); #1;
    chk("wr_c1", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}, {1'b1, 1'b0, 20'd16});
    wait_rd(1);

    // Out-of-range read and write.
    chk("rng_pre", bus.err_range, 0);
    cyc(); bus.dr_en = 1'b1; bus.dr_addr = 32'h00004000;
    #1;
    chk("rng_rd_en", bus.ram_en, 0);
    push(1, "rng_dr", 32'h0, cnt + 1);
    cyc(); idle(); #1;
    wait_rd(1);
    chk("rng_set", bus.err_range, 1);
    cyc(); bus.dw_en = 1'b1; bus.dw_addr = 32'h00004040; bus.dw_data = 32'h00000BAD;
    #1;
    chk("rng_wr_en", bus.ram_en, 0);
    cyc(); idle(); bus.dr_en = 1'b1; bus.dr_addr = 32'h40;
    push(1, "rng_wr_drop", 32'hDEADBEEF, cnt + 1);
    cyc(); idle(); #1;
    wait_rd(1);
    chk("rng_sticky", bus.err_range, 1);

    // Strobe while the pending request wins: not an overrun.
    cyc();
    bus.dw_en = 1'b1; bus.dw_addr = 32'h58; bus.dw_data = 32'h5;
    bus.dr_en = 1'b1; bus.dr_addr = 32'h30;
    cyc(); idle(); bus.dr_en = 1'b1; bus.dr_addr = 32'h34;
    #1;
    chk("nov_c1", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}, {1'b1, 1'b0, 20'd12});
    cyc(); idle();
    push(1, "nov_dr", 32'h44444444, cnt + 1);
    #1;
    chk("nov_c2_addr", bus.ram_addr, 13);
    chk("nov_err", bus.err_overrun, 0);
    wait_rd(1);

    // Overrun: second dr replaces the first while dw holds the RAM.
    cyc();
    bus.dw_en = 1'b1; bus.dw_addr = 32'h50; bus.dw_data = 32'h1;
    bus.dr_en = 1'b1; bus.dr_addr = 32'h30;
    #1;
    chk("ovr_c0_addr", bus.ram_addr, 20);
    cyc(); bus.dw_addr = 32'h54; bus.dr_addr = 32'h34;
    #1;
    chk("ovr_c1_we", bus.ram_we, 1);
    cyc(); idle();
    push(1, "ovr_dr", 32'h44444444, cnt + 1);
    #1;
    chk("ovr_c2", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr)}, {1'b1, 1'b0, 20'd13});
    chk("ovr_err", bus.err_overrun, 1);
    wait_rd(1);
    chk("ovr_single", bus.ram_en, 0);

    // Async reset with a read in flight.
    cyc();
    bus.dw_en = 1'b1; bus.dw_addr = 32'h5C; bus.dw_data = 32'h7;
    bus.dr_en = 1'b1; bus.dr_addr = 32'h30;
    cyc(); idle();
    #1;
    chk("ar_pend_win", {bus.ram_en, 20'(bus.ram_addr)}, {1'b1, 20'd12});
    rst_n = 1'b0;
    #1;
    chk("ar_ram", {bus.ram_en, bus.ram_we, 20'(bus.ram_addr), bus.ram_wdata}, 0);
    chk("ar_rd", {bus.ir_valid, bus.ir_data, bus.dr_valid, bus.dr_data}, 0);
    chk("ar_err", {bus.err_range, bus.err_overrun}, 0);
    cyc(); cyc();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("ar_post", {bus.ram_en, bus.dr_valid, bus.ir_valid}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
